instr_issue_queue: RTL

- Sits directly upstream of the systolic-array controller and drives its 64-bit `instruction` input every clock.
- Buffers host-written instructions in a FIFO and issues at most one per cycle.
- Inserts NOP bubbles (all-zero instruction) while a compute opcode is in flight.
- Parks issue on a HALT opcode until software resumes it.

---
 rtl/instr_issue_queue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_issue_queue
// Purpose  : FIFO-buffered instruction issue with compute-hold NOP bubbles and
//            HALT parking. Optional macro ISSUE_COUNTER_EN adds issue_count.
// Revision : 1.0 - initial release
// ============================================================================
module instr_issue_queue #(
  parameter int DEPTH        = 8,
  parameter int INSTR_W      = 64,
  parameter int COMPUTE_HOLD = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_valid,
  input  logic [INSTR_W-1:0]         host_instr,
  output logic                       host_ready,
  input  logic                       resume,
  output logic [INSTR_W-1:0]         instruction,
  output logic [$clog2(DEPTH):0]     fill_count,
  output logic                       halted,
  output logic                       busy
`ifdef ISSUE_COUNTER_EN
  ,
  output logic [15:0]                issue_count
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH) + 1;
  localparam int c_HW = $clog2(COMPUTE_HOLD + 1);

  localparam logic [1:0] c_RUN  = 2'd0;
  localparam logic [1:0] c_HOLD = 2'd1;
  localparam logic [1:0] c_HALT = 2'd2;

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]    r_wr_ptr;
  logic [c_AW-1:0]    r_rd_ptr;
  logic [c_CW-1:0]    r_count;
  logic [1:0]         r_state;
  logic [c_HW-1:0]    r_hold_cnt;
  logic [INSTR_W-1:0] r_instr;

  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic [INSTR_W-1:0] w_head;
  logic [4:0]         w_opcode;

  // Full blocks writes even when a pop happens in the same cycle.
  assign w_full   = (r_count == c_CW'(DEPTH));
  assign w_push   = host_valid && !w_full;
  assign w_pop    = (r_state == c_RUN) && (r_count != '0);
  assign w_head   = r_mem[r_rd_ptr];
  assign w_opcode = w_head[4:0];

  assign host_ready  = !w_full;
  assign instruction = r_instr;
  assign fill_count  = r_count;
  assign halted      = (r_state == c_HALT);
  assign busy        = (r_state == c_HOLD) || (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= host_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_state    <= c_RUN;
      r_hold_cnt <= '0;
      r_instr    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase

      // A popped word is shown for exactly one cycle; every other cycle is NOP.
      r_instr <= w_pop ? w_head : '0;

      case (r_state)
        c_RUN: begin
          if (w_pop) begin
            if ((w_opcode == 5'b00001) || (w_opcode == 5'b00010)) begin
              r_state    <= c_HOLD;
              r_hold_cnt <= c_HW'(COMPUTE_HOLD);
            end else if (w_opcode == 5'b11111) begin
              r_state <= c_HALT;
            end
          end
        end
        c_HOLD: begin
          r_hold_cnt <= r_hold_cnt - c_HW'(1);
          if (r_hold_cnt == c_HW'(1)) begin
            r_state <= c_RUN;
          end
        end
        c_HALT: begin
          if (resume) begin
            r_state <= c_RUN;
          end
        end
        default: r_state <= c_RUN;
      endcase
    end
  end

`ifdef ISSUE_COUNTER_EN
  logic [15:0] r_issue_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_count <= '0;
    end else if (w_pop && (w_opcode != 5'b00000)) begin
      r_issue_count <= r_issue_count + 16'd1;
    end
  end

  assign issue_count = r_issue_count;
`endif

endmodule
`default_nettype wire
